// File: rtl/mips32_fetch_queue.sv
// mips32_fetch_queue: credit-based instruction prefetch queue with redirect flush and HLT stop.
// Define FETCH_FLUSH_CNT_EN to build the saturating redirect counter on flush_cnt.
module mips32_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk1,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [9:0]  imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dq_valid,
  output logic [31:0] dq_ir,
  output logic [31:0] dq_npc,
  input  logic        dq_ready,
  output logic        halted,
  output logic [15:0] flush_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

  logic [31:0]   pc_q, pc_d, ret_pc_q, ret_pc_d;
  logic [CW-1:0] outs_q, outs_d, drop_q, drop_d, count_q, count_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic          halted_q, halted_d, hlt_q, hlt_d;
  logic [31:0]   ir_q [DEPTH];
  logic [31:0]   ir_d [DEPTH];
  logic [31:0]   npc_q [DEPTH];
  logic [31:0]   npc_d [DEPTH];
  logic          redir, gnt, push, pop;

  assign redir     = redirect && !halted_q;
  assign imem_req  = rst_n && !halted_q && !hlt_q && !redirect &&
                     ((CW+1)'(outs_q) + (CW+1)'(count_q) < CAP);
  assign imem_addr = pc_q[9:0];
  assign gnt       = imem_req && imem_gnt;
  // stale returns and anything behind a queued HLT are consumed without a push
  assign push      = imem_rvalid && drop_q == '0 && !hlt_q && !redir;
  assign dq_valid  = count_q != '0 && !halted_q;
  assign pop       = dq_valid && dq_ready && !redir;
  assign dq_ir     = ir_q[rd_q];
  assign dq_npc    = npc_q[rd_q];
  assign halted    = halted_q;

  always_comb begin
    pc_d     = pc_q + 32'(gnt);
    ret_pc_d = ret_pc_q;
    outs_d   = outs_q + CW'(gnt) - CW'(imem_rvalid);
    drop_d   = drop_q - CW'(imem_rvalid && drop_q != '0);
    count_d  = count_q + CW'(push) - CW'(pop);
    rd_d     = rd_q + AW'(pop);
    wr_d     = wr_q;
    hlt_d    = hlt_q;
    halted_d = halted_q || (pop && dq_ir[31:26] == 6'h3f);
    ir_d     = ir_q;
    npc_d    = npc_q;
    if (push) begin
      ir_d[wr_q]  = imem_rdata;
      npc_d[wr_q] = ret_pc_q + 32'd1;
      wr_d        = wr_q + AW'(1);
      ret_pc_d    = ret_pc_q + 32'd1;
      hlt_d       = imem_rdata[31:26] == 6'h3f;
    end
    // every request still in flight after this cycle belongs to the old path
    if (redir) begin
      pc_d     = redirect_pc;
      ret_pc_d = redirect_pc;
      drop_d   = outs_d;
      count_d  = '0;
      rd_d     = '0;
      wr_d     = '0;
      hlt_d    = 1'b0;
      halted_d = halted_q;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      ret_pc_q <= '0;
      outs_q   <= '0;
      drop_q   <= '0;
      count_q  <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      hlt_q    <= 1'b0;
      halted_q <= 1'b0;
      ir_q     <= '{default: '0};
      npc_q    <= '{default: '0};
    end else begin
      pc_q     <= pc_d;
      ret_pc_q <= ret_pc_d;
      outs_q   <= outs_d;
      drop_q   <= drop_d;
      count_q  <= count_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      hlt_q    <= hlt_d;
      halted_q <= halted_d;
      ir_q     <= ir_d;
      npc_q    <= npc_d;
    end
  end

`ifdef FETCH_FLUSH_CNT_EN
  logic [15:0] flush_cnt_q, flush_cnt_d;
  assign flush_cnt_d = flush_cnt_q + 16'(redir && flush_cnt_q != 16'hffff);
  assign flush_cnt   = flush_cnt_q;
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) flush_cnt_q <= '0;
    else flush_cnt_q <= flush_cnt_d;
  end
`else
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_mips32_fetch_queue.sv
// tb_mips32_fetch_queue: directed vectors, corner sequences and random traffic against a transaction-level model.
module tb_mips32_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dq_valid;
  logic [31:0] dq_ir, dq_npc;
  logic        dq_ready = 1'b0;
  logic        halted;
  logic [15:0] flush_cnt;

  mips32_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk1(clk1), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .dq_valid(dq_valid),
    .dq_ir(dq_ir), .dq_npc(dq_npc), .dq_ready(dq_ready), .halted(halted),
    .flush_cnt(flush_cnt)
  );

  always #5 clk1 = ~clk1;
  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  typedef struct {logic [31:0] addr; int due; bit stale;} fl_t;
  typedef struct {logic [31:0] ir; logic [31:0] npc;} ent_t;
  typedef struct {bit rdy; bit req; logic [9:0] addr; bit vld; logic [31:0] ir; logic [31:0] npc;} vec_t;

  int checks = 0, errors = 0;
  fl_t infl[$];
  ent_t mq[$];
  logic [31:0] m_pc;
  bit m_halted, m_hltq;
  int m_flush, gnt_pct, lat_lo, lat_hi, last_due, grants, hp_cyc, h_cyc;
  logic [31:0] pop_ir[$], pop_npc[$];
  logic [31:0] mem_arr [1024];
  vec_t tv [9];

  function automatic bit is_hlt(input logic [31:0] w);
    return w[31:26] == 6'h3f;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    infl.delete();
    mq.delete();
    m_pc = '0;
    m_halted = 1'b0;
    m_hltq = 1'b0;
    m_flush = 0;
    last_due = -1;
  endtask

  task automatic model_check();
    bit er, ev;
    er = !m_halted && !m_hltq && !redirect && (infl.size() + mq.size() < DEPTH);
    ev = mq.size() != 0 && !m_halted;
    chk("req", 32'(imem_req), 32'(er));
    if (er) chk("addr", 32'(imem_addr), 32'(m_pc[9:0]));
    chk("valid", 32'(dq_valid), 32'(ev));
    if (ev) begin
      chk("ir", dq_ir, mq[0].ir);
      chk("npc", dq_npc, mq[0].npc);
    end
    chk("halted", 32'(halted), 32'(m_halted));
`ifdef FETCH_FLUSH_CNT_EN
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
`else
    chk("flush_cnt", 32'(flush_cnt), 32'd0);
`endif
  endtask

  task automatic drive(input bit rdy, input bit rd, input logic [31:0] rpc);
    @(negedge clk1);
    dq_ready = rdy;
    redirect = rd;
    redirect_pc = rpc;
    imem_gnt = int'($urandom_range(99)) < gnt_pct;
    if (infl.size() != 0 && infl[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata = mem_arr[infl[0].addr[9:0]];
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata = $urandom;
    end
    #1;
    if (halted && h_cyc < 0) h_cyc = cyc;
    model_check();
  endtask

  task automatic commit();
    fl_t r;
    ent_t e;
    bit red, ret, g;
    int d;
    red = redirect && !m_halted;
    ret = imem_rvalid;
    g = imem_req && imem_gnt;
    if (dq_valid && dq_ready && !redirect) begin
      pop_ir.push_back(dq_ir);
      pop_npc.push_back(dq_npc);
      if (is_hlt(dq_ir)) hp_cyc = cyc;
    end
    if (ret) r = infl.pop_front();
    if (red) begin
      foreach (infl[i]) infl[i].stale = 1'b1;
      mq.delete();
      m_pc = redirect_pc;
      m_hltq = 1'b0;
      m_flush++;
    end else begin
      if (mq.size() != 0 && !m_halted && dq_ready) begin
        if (is_hlt(mq[0].ir)) m_halted = 1'b1;
        void'(mq.pop_front());
      end
      if (ret && !r.stale && !m_hltq) begin
        e.ir = mem_arr[r.addr[9:0]];
        e.npc = r.addr + 32'd1;
        mq.push_back(e);
        if (is_hlt(e.ir)) m_hltq = 1'b1;
      end
    end
    if (g) begin
      d = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      infl.push_back('{m_pc, d, 1'b0});
      m_pc = m_pc + 32'd1;
      grants++;
    end
    @(posedge clk1);
  endtask

  task automatic step(input bit rdy, input bit rd, input logic [31:0] rpc);
    drive(rdy, rd, rpc);
    commit();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect = 1'b0;
    dq_ready = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(dq_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    model_clear();
    pop_ir.delete();
    pop_npc.delete();
    grants = 0;
    hp_cyc = -1;
    h_cyc = -1;
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  task automatic setup(input int gp, input int lo, input int hi);
    gnt_pct = gp;
    lat_lo = lo;
    lat_hi = hi;
    for (int i = 0; i < 1024; i++) mem_arr[i] = 32'h2400_0000 | 32'(i);
    do_reset();
  endtask

  initial begin
    tv[0] = '{1'b1, 1'b1, 10'd0, 1'b0, 32'h0, 32'h0};
    tv[1] = '{1'b1, 1'b1, 10'd1, 1'b0, 32'h0, 32'h0};
    tv[2] = '{1'b1, 1'b1, 10'd2, 1'b1, 32'h2801_0078, 32'd1};
    tv[3] = '{1'b1, 1'b1, 10'd3, 1'b1, 32'h0c63_1800, 32'd2};
    tv[4] = '{1'b1, 1'b1, 10'd4, 1'b1, 32'h2022_0000, 32'd3};
    tv[5] = '{1'b1, 1'b1, 10'd5, 1'b1, 32'h2400_0003, 32'd4};
    tv[6] = '{1'b0, 1'b1, 10'd6, 1'b1, 32'h2400_0004, 32'd5};
    tv[7] = '{1'b0, 1'b1, 10'd7, 1'b1, 32'h2400_0004, 32'd5};
    tv[8] = '{1'b1, 1'b0, 10'd0, 1'b1, 32'h2400_0004, 32'd5};
    #2;

    // in-order fetch from reset, then back-pressure filling the queue
    setup(100, 1, 1);
    mem_arr[0] = 32'h2801_0078;
    mem_arr[1] = 32'h0c63_1800;
    mem_arr[2] = 32'h2022_0000;
    for (int i = 0; i < 9; i++) begin
      drive(tv[i].rdy, 1'b0, 32'h0);
      chk($sformatf("t%0d_req", i), 32'(imem_req), 32'(tv[i].req));
      if (tv[i].req) chk($sformatf("t%0d_addr", i), 32'(imem_addr), 32'(tv[i].addr));
      chk($sformatf("t%0d_valid", i), 32'(dq_valid), 32'(tv[i].vld));
      if (tv[i].vld) begin
        chk($sformatf("t%0d_ir", i), dq_ir, tv[i].ir);
        chk($sformatf("t%0d_npc", i), dq_npc, tv[i].npc);
      end
      commit();
    end

    // decode stalled: exactly DEPTH grants, then nothing lost
    setup(100, 1, 1);
    repeat (10) step(1'b0, 1'b0, 32'h0);
    chk("full_grants", 32'(grants), 32'(DEPTH));
    drive(1'b0, 1'b0, 32'h0);
    chk("full_req", 32'(imem_req), 32'd0);
    commit();
    repeat (8) step(1'b1, 1'b0, 32'h0);
    if (pop_ir.size() < 4) chk("full_pops", 32'(pop_ir.size()), 32'd4);
    else for (int i = 0; i < 4; i++) begin
      chk($sformatf("full_pop%0d_ir", i), pop_ir[i], 32'h2400_0000 | 32'(i));
      chk($sformatf("full_pop%0d_npc", i), pop_npc[i], 32'(i + 1));
    end

    // redirect with three requests in flight at 3-cycle latency
    setup(100, 3, 3);
    repeat (3) step(1'b1, 1'b0, 32'h0);
    chk("redir_inflight", 32'(infl.size()), 32'd3);
    step(1'b1, 1'b1, 32'd40);
    pop_ir.delete();
    pop_npc.delete();
    for (int i = 0; i < 30 && pop_ir.size() == 0; i++) step(1'b1, 1'b0, 32'h0);
    if (pop_ir.size() == 0) chk("redir_timeout", 32'd0, 32'd1);
    else begin
      chk("redir_ir", pop_ir[0], 32'h2400_0028);
      chk("redir_npc", pop_npc[0], 32'd41);
    end

    // HLT at address 7 stops fetch, halted follows the pop, redirect ignored
    setup(100, 1, 1);
    mem_arr[7] = 32'hfc00_0000;
    repeat (25) step(1'b1, 1'b0, 32'h0);
    chk("hlt_grants", 32'(grants), 32'd9);
    chk("hlt_pop_cyc", 32'(hp_cyc >= 0), 32'd1);
    chk("hlt_rise", 32'(h_cyc), 32'(hp_cyc + 1));
    drive(1'b1, 1'b1, 32'd100);
    chk("hlt_redir_req", 32'(imem_req), 32'd0);
    commit();
    drive(1'b1, 1'b0, 32'h0);
    chk("hlt_after_req", 32'(imem_req), 32'd0);
    chk("hlt_after_valid", 32'(dq_valid), 32'd0);
    chk("hlt_after_halted", 32'(halted), 32'd1);
    commit();

    // asynchronous reset with two requests outstanding
    setup(100, 3, 3);
    repeat (2) step(1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    do_reset();
    drive(1'b1, 1'b0, 32'h0);
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", 32'(imem_addr), 32'd0);
    commit();
    repeat (10) step(1'b1, 1'b0, 32'h0);

    // five accepted redirects
    setup(100, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 32'(200 + 8 * i));
      step(1'b1, 1'b0, 32'h0);
    end
    drive(1'b1, 1'b0, 32'h0);
`ifdef FETCH_FLUSH_CNT_EN
    chk("flush5", 32'(flush_cnt), 32'd5);
`else
    chk("flush5", 32'(flush_cnt), 32'd0);
`endif
    commit();

    // random traffic, including redirects near the 32-bit wrap
    setup(70, 1, 3);
    for (int i = 0; i < 1024; i++) begin
      mem_arr[i] = $urandom;
      if (is_hlt(mem_arr[i])) mem_arr[i][31] = 1'b0;
      if ($urandom_range(63) == 0) mem_arr[i][31:26] = 6'h3f;
    end
    for (int n = 0; n < 3000; n++) begin
      gnt_pct = int'($urandom_range(100, 30));
      step($urandom_range(3) != 0, $urandom_range(19) == 0,
           ($urandom_range(3) == 0) ? 32'hffff_fffe : $urandom);
      if (m_halted && $urandom_range(7) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
